// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcode field, opcodes, control encodings, states and control bundle.
package multicycle_control_pkg;
    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
        RTYPEWB, BEQEX, ADDIEX, ORIEX, IMMWB, JEX
    } state_e;
    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic       ext_zero;
        logic [1:0] alusrcb;
        logic [1:0] alu_op;
        logic [1:0] pcsrc;
        logic       illegal;
        logic       retired;
    } ctrl_t;
    function automatic logic [5:0] op_of(input logic [31:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction
    function automatic logic legal_op(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW};
    endfunction
endpackage

// File: rtl/multicycle_control_decode.sv
// multicycle_control_decode: per-state control outputs, including handshake-qualified enables.
module multicycle_control_decode
    import multicycle_control_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.alu_op  = ALU_ADD;
                ctrl.pcsrc   = PC_ALU;
                ctrl.pc_we   = mem_ready;
                ctrl.ir_we   = mem_ready;
            end
            DECODE: begin
                ctrl.alusrcb = SRCB_IMM4;
                ctrl.illegal = !legal_op(opcode);
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_we   = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.retired  = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.retired = mem_ready;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.alu_op  = ALU_FUNCT;
            end
            RTYPEWB: begin
                ctrl.reg_we  = 1'b1;
                ctrl.regdst  = 1'b1;
                ctrl.retired = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.alu_op  = ALU_SUB;
                ctrl.pcsrc   = PC_ALUOUT;
                ctrl.pc_we   = zero;
                ctrl.retired = 1'b1;
            end
            ADDIEX, ORIEX: begin
                ctrl.alusrca  = 1'b1;
                ctrl.alusrcb  = SRCB_IMM;
                ctrl.alu_op   = (state == ORIEX) ? ALU_OR : ALU_ADD;
                ctrl.ext_zero = (state == ORIEX);
            end
            IMMWB: begin
                ctrl.reg_we  = 1'b1;
                ctrl.retired = 1'b1;
            end
            JEX: begin
                ctrl.pcsrc   = PC_JUMP;
                ctrl.pc_we   = 1'b1;
                ctrl.retired = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle CPU control FSM with retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrca,
    output logic        ext_zero,
    output logic [1:0]  alusrcb,
    output logic [1:0]  alu_op,
    output logic [1:0]  pcsrc,
    output logic        illegal,
    output logic        retired,
    output logic [31:0] instr_count
);
    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [5:0]  opcode;
    ctrl_t       ctrl, out;

    assign opcode = op_of(instr);

    multicycle_control_decode u_decode (
        .state     (state_q),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE:  state_d = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                               (opcode == OP_RTYPE) ? RTYPEEX :
                               (opcode == OP_BEQ)   ? BEQEX   :
                               (opcode == OP_ADDI)  ? ADDIEX  :
                               (opcode == OP_ORI)   ? ORIEX   :
                               (opcode == OP_J)     ? JEX     : FETCH;
            MEMADR:  state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = IMMWB;
            ORIEX:   state_d = IMMWB;
            default: state_d = FETCH;
        endcase
        count_d = ctrl.retired ? count_q + 32'd1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Reset forces every output low, so an abandoned memory wait never leaks an enable.
    assign out         = reset ? '0 : ctrl;
    assign instr_count = reset ? '0 : count_q;
    assign {pc_we, ir_we, reg_we, mem_req, mem_we, iord, regdst, memtoreg, alusrca,
            ext_zero, alusrcb, alu_op, pcsrc, illegal, retired} = out;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream checked against a per-instruction step model.
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_we, ir_we, reg_we, mem_req, mem_we, iord, regdst, memtoreg, alusrca, ext_zero;
    logic [1:0]  alusrcb, alu_op, pcsrc;
    logic        illegal, retired;
    logic [31:0] instr_count;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic       ext_zero;
        logic [1:0] alusrcb;
        logic [1:0] alu_op;
        logic [1:0] pcsrc;
        logic       illegal;
        logic       retired;
    } ctl_t;

    typedef struct {
        ctl_t base;
        ctl_t on_rdy;
        bit   waits;
        bit   zdep;
    } step_t;

    multicycle_control dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .ext_zero(ext_zero), .alusrcb(alusrcb), .alu_op(alu_op), .pcsrc(pcsrc),
        .illegal(illegal), .retired(retired), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    ctl_t        act;
    ctl_t        exp_ctl = '0;
    logic [31:0] exp_count = '0;
    bit          exp_valid = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ret_seen = 0;
    step_t       steps[$];

    assign act = {pc_we, ir_we, reg_we, mem_req, mem_we, iord, regdst, memtoreg, alusrca,
                  ext_zero, alusrcb, alu_op, pcsrc, illegal, retired};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (exp_valid) begin
            chk("ctrl", 32'(act), 32'(exp_ctl));
            chk("instr_count", instr_count, reset ? 32'd0 : exp_count);
            if (retired) ret_seen++;
        end
    end

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h0D, 6'h23, 6'h2B};
    endfunction

    task automatic push(input ctl_t b, input ctl_t r, input bit w, input bit z);
        steps.push_back('{base: b, on_rdy: r, waits: w, zdep: z});
    endtask

    // Expected cycle-by-cycle controls of one instruction, derived from its opcode.
    task automatic plan(input logic [5:0] op);
        ctl_t none;
        none = '0;
        steps.delete();
        push(ctl_t'{mem_req: 1'b1, alusrcb: 2'b01, default: '0}, ctl_t'{pc_we: 1'b1, ir_we: 1'b1, default: '0}, 1, 0);
        push(ctl_t'{alusrcb: 2'b11, illegal: !is_legal(op), default: '0}, none, 0, 0);
        case (op)
            6'h23: begin
                push(ctl_t'{alusrca: 1'b1, alusrcb: 2'b10, default: '0}, none, 0, 0);
                push(ctl_t'{mem_req: 1'b1, iord: 1'b1, default: '0}, none, 1, 0);
                push(ctl_t'{reg_we: 1'b1, memtoreg: 1'b1, retired: 1'b1, default: '0}, none, 0, 0);
            end
            6'h2B: begin
                push(ctl_t'{alusrca: 1'b1, alusrcb: 2'b10, default: '0}, none, 0, 0);
                push(ctl_t'{mem_req: 1'b1, mem_we: 1'b1, iord: 1'b1, default: '0}, ctl_t'{retired: 1'b1, default: '0}, 1, 0);
            end
            6'h00: begin
                push(ctl_t'{alusrca: 1'b1, alu_op: 2'b10, default: '0}, none, 0, 0);
                push(ctl_t'{reg_we: 1'b1, regdst: 1'b1, retired: 1'b1, default: '0}, none, 0, 0);
            end
            6'h04: push(ctl_t'{alusrca: 1'b1, alu_op: 2'b01, pcsrc: 2'b01, retired: 1'b1, default: '0}, none, 0, 1);
            6'h08, 6'h0D: begin
                push(ctl_t'{alusrca: 1'b1, alusrcb: 2'b10, alu_op: (op == 6'h0D) ? 2'b11 : 2'b00,
                            ext_zero: (op == 6'h0D), default: '0}, none, 0, 0);
                push(ctl_t'{reg_we: 1'b1, retired: 1'b1, default: '0}, none, 0, 0);
            end
            6'h02: push(ctl_t'{pcsrc: 2'b10, pc_we: 1'b1, retired: 1'b1, default: '0}, none, 0, 0);
            default: ;
        endcase
    endtask

    task automatic tick(input bit rst_v, input bit rdy, input bit z, input ctl_t e);
        @(negedge clk);
        reset = rst_v;
        mem_ready = rdy;
        zero = z;
        exp_ctl = rst_v ? '0 : e;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        if (rst_v) exp_count = '0;
        else if (e.retired) exp_count = exp_count + 32'd1;
    endtask

    // rmode: 0 ready always, 1 random, 2 low 5 cycles per wait; zmode: 0 random, 1 force 1, 2 force 0.
    task automatic run(input logic [31:0] iv, input int rmode, input int zmode, input int abort_at, output int ncyc);
        bit   rdy, z;
        int   low;
        ctl_t e;
        instr = iv;
        plan(iv[31:26]);
        ncyc = 0;
        for (int i = 0; i < steps.size(); i++) begin
            if (i == abort_at) begin
                tick(1, 1, 1, '0);
                return;
            end
            low = 0;
            do begin
                rdy = (rmode == 0) ? 1'b1 : (rmode == 2) ? (low >= 5) : ($urandom_range(0, 2) != 0);
                z = (zmode == 0) ? 1'($urandom) : (zmode == 1);
                e = steps[i].base;
                if (steps[i].zdep) e.pc_we = z;
                if (steps[i].waits && rdy) e = ctl_t'(e | steps[i].on_rdy);
                tick(0, rdy, z, e);
                ncyc++;
                low++;
            end while (steps[i].waits && !rdy);
        end
    endtask

    initial begin
        int n;
        logic [5:0] ops [8];
        logic [5:0] op;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h0D, 6'h02, 6'h3F};
        tick(1, 1, 0, '0);
        tick(1, 0, 0, '0);
        ret_seen = 0;
        run(32'h8C080004, 0, 0, -1, n);
        chk("lw_cycles", n, 5);
        chk("lw_retired", ret_seen, 1);
        chk("lw_count", instr_count, 1);
        run(32'h3508FFFF, 0, 0, -1, n);
        chk("ori_cycles", n, 4);
        run(32'h2108FFFF, 0, 0, -1, n);
        chk("addi_cycles", n, 4);
        run(32'h11080003, 0, 1, -1, n);
        chk("beq_taken_cycles", n, 3);
        run(32'h11080003, 0, 2, -1, n);
        chk("beq_not_taken_cycles", n, 3);
        run(32'hAD080004, 2, 0, -1, n);
        chk("sw_wait_cycles", n, 14);
        chk("sw_count", instr_count, 6);
        ret_seen = 0;
        run(32'hFC000000, 0, 0, -1, n);
        chk("illegal_cycles", n, 2);
        chk("illegal_retired", ret_seen, 0);
        chk("illegal_count", instr_count, 6);
        run(32'h8C080004, 0, 0, 3, n);
        chk("rst_count", instr_count, 0);
        for (int k = 0; k < 300; k++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 6'h3F) begin
                do op = 6'($urandom); while (is_legal(op));
            end
            run({op, 26'($urandom)}, 1, 0, ($urandom_range(0, 19) == 0) ? 3 : -1, n);
        end
        exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr  input  32  current instruction register contents; opcode in `op (bits 31:26).
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes the current request this cycle.
REQ-007 pc_we, ir_we, reg_we, mem_req, mem_we  output  1 each  PC, IR and register-file write enables; memory request; memory write.
REQ-008 iord, regdst, memtoreg, alusrca, ext_zero  output  1 each  memory address = ALUOut; rd destination; writeback from MDR; ALU A = register; extender zero-pads.
REQ-009 alusrcb  output  2  00 = reg B, 01 = const 4, 10 = ext imm, 11 = ext imm << 2.
REQ-010 alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = or.
REQ-011 pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-012 illegal, retired  output  1 each  one-cycle pulses; instr_count  output  32  retired-instruction count.

Function
REQ-013 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ORIEX, IMMWB, JEX.
REQ-014 All outputs not listed for a state SHALL be 0.
REQ-015 FETCH: mem_req = 1, iord = 0, alusrcb = 01, alu_op = 00, pcsrc = 00. Stay in FETCH until mem_ready = 1. In the mem_ready cycle, ir_we = pc_we = 1, then go to DECODE.
REQ-016 DECODE: alusrcb = 11, alu_op = 00. Next state by opcode:
- LW 0x23 and SW 0x2B -> MEMADR
- R-type 0x00 -> RTYPEEX
- BEQ 0x04 -> BEQEX
- ADDI 0x08 -> ADDIEX
- ORI 0x0D -> ORIEX
- J 0x02 -> JEX
- any other opcode: pulse illegal, go to FETCH, no retire
REQ-017 MEMADR: alusrca = 1, alusrcb = 10, alu_op = 00. Next state MEMRD for LW, MEMWR for SW.
REQ-018 MEMRD: mem_req = 1, iord = 1. Hold until mem_ready, then go to MEMWB. MEMWB: reg_we = 1, memtoreg = 1, regdst = 0, then FETCH.
REQ-019 MEMWR: mem_req = mem_we = iord = 1. Hold until mem_ready, then FETCH.
REQ-020 RTYPEEX: alusrca = 1, alusrcb = 00, alu_op = 10, then RTYPEWB. RTYPEWB: reg_we = 1, regdst = 1, then FETCH.
REQ-021 BEQEX: alusrca = 1, alusrcb = 00, alu_op = 01, pcsrc = 01, pc_we = zero (combinational), then FETCH.
REQ-022 ADDIEX: alusrca = 1, alusrcb = 10, alu_op = 00. ORIEX: same controls but alu_op = 11 and ext_zero = 1. Both go to IMMWB. IMMWB: reg_we = 1, regdst = 0, memtoreg = 0, then FETCH.
REQ-023 JEX: pcsrc = 10, pc_we = 1, then FETCH.
REQ-024 ext_zero SHALL be 0 in every state except ORIEX; DECODE branch offsets are always sign-extended.
REQ-025 Handshake: mem_req and all its companion controls SHALL stay stable until the mem_ready cycle. mem_ready SHALL be ignored while mem_req = 0.
REQ-026 retired SHALL pulse for one cycle on the final state of each legal instruction (MEMWB, MEMWR-done, RTYPEWB, BEQEX, IMMWB, JEX). instr_count increments on that same edge and wraps from 0xFFFFFFFF to 0.

Reset
REQ-027 While reset = 1, all outputs SHALL be 0, including mem_req, illegal and retired. The state SHALL load FETCH and instr_count SHALL load 0 on the edge.
REQ-028 Reset asserted mid-wait in MEMRD or MEMWR SHALL abandon the request with no write enable asserted. A mem_ready arriving in that same cycle SHALL be ignored.

Structure
REQ-029 The following SHALL live in the shared defines file: the `op field, opcode values, alu_op, alusrcb and pcsrc encodings, and the state encodings.
REQ-030 Output decoding SHALL be a sub-module, multicycle_control_decode (state, opcode, zero, mem_ready -> control outputs). The state register, next-state logic and counter SHALL stay in the top.

Verification
REQ-031 Sequence: reset high for 2 cycles, then LW 0x8C080004 with mem_ready tied 1. Required: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; reg_we and memtoreg high in MEMWB; retired pulses once; instr_count = 1.
REQ-032 ORI 0x3508FFFF: ext_zero = 1 and alu_op = 11 only in ORIEX. ADDI 0x2108FFFF: ext_zero stays 0 throughout.
REQ-033 BEQ with zero = 1: pc_we = 1 and pcsrc = 01 in BEQEX. BEQ with zero = 0: pc_we = 0. Both take 3 cycles.
REQ-034 mem_ready held low 5 cycles in FETCH and then in MEMWR: state holds, mem_req/mem_we/iord stay stable, no ir_we, and no retire before mem_ready.
REQ-035 Opcode 0x3F yields illegal = 1 for one cycle and a return to FETCH with instr_count unchanged. Reset during MEMRD yields FETCH next cycle, all outputs 0 during reset, and instr_count = 0.
